mem_arbiter2: RTL and testbench
===============================

# mem_arbiter2

Two-requester arbiter that shares the single `Memory32` port between the `Pipeline` data/instruction port (requester A, priority) and a secondary master such as a bootloader or DMA engine (requester B). It sits between both masters and the memory. It multiplexes requests, routes the one-cycle-latency read data back to the issuing master, prevents B starvation with a wait counter, and supports bounded locked bursts for B.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: word-address width passed to memory.
- `STARVE_LIMIT`, 8: consecutive cycles B may wait before it is force-granted; range 1..255.
- `MAX_BURST`, 16: maximum consecutive locked B grants; range 1..255.

Ports:
- `clk` in 1: clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `a_valid`, `a_write` in 1 each; `a_wmask` in 4; `a_wdata` in 32; `a_addr` in ADDR_WIDTH: requester A command.
- `a_ready` out 1: A command accepted this cycle.
- `a_rvalid` out 1; `a_rdata` out 32: A read response.
- `b_valid`, `b_write`, `b_lock` in 1 each; `b_wmask` in 4; `b_wdata` in 32; `b_addr` in ADDR_WIDTH: requester B command. `b_lock` requests that the grant be held for the next beat.
- `b_ready`, `b_rvalid` out 1 each; `b_rdata` out 32: requester B handshake and response.
- `mem_valid`, `mem_write` out 1 each; `mem_wmask` out 4; `mem_wdata` out 32; `mem_addr` out ADDR_WIDTH: memory command.
- `mem_rdata` in 32: memory read data, valid one cycle after the read command.

## Operation
- A beat is accepted when `x_valid & x_ready`. At most one grant per cycle. Grant is combinational from inputs and registered state.
- Grant priority, highest first:
  1. State LOCKED and `b_valid`: grant B.
  2. `b_valid` and `wait_cnt == STARVE_LIMIT`: grant B.
  3. `a_valid`: grant A.
  4. `b_valid`: grant B.
- When nothing is granted: `mem_valid` = 0 and all `mem_*` command fields = 0. Otherwise the `mem_*` fields are a mux of the granted requester's fields.
- States: IDLE, LOCKED.
  - IDLE → LOCKED: on an accepted B beat with `b_lock` = 1 and `burst_cnt + 1 < MAX_BURST`.
  - LOCKED → IDLE on any of:
    - an accepted B beat with `b_lock` = 0;
    - `b_valid` = 0 in LOCKED, which is an idle release with no grant issued;
    - `burst_cnt` reaching MAX_BURST.
- `burst_cnt`:
  - increments on each accepted B beat while B holds or enters the lock;
  - clears on transition to IDLE;
  - after a forced release, A wins the next cycle if `a_valid`, because LOCKED is not re-entered that cycle.
- `wait_cnt`, 8 bits:
  - increments, saturating at STARVE_LIMIT, when `b_valid & !b_ready`;
  - clears when B is granted or `b_valid` = 0.
- Response routing:
  - register `resp_owner` (NONE/A/B) is set to the granted requester on an accepted read (`!write`), otherwise NONE.
  - Next cycle the matching `x_rvalid` = 1 and `x_rdata` = `mem_rdata`.
  - The non-owner's `x_rdata` = 0, so responses can be OR-combined.
- Writes produce no response.

## Timing
- Command path is combinational: request to `mem_*` and `x_ready` in the same cycle.
- Read latency is exactly one cycle after acceptance: `x_rvalid` is high in cycle N+1 for a beat accepted in cycle N.
- Back-to-back reads from alternating requesters are allowed every cycle, with responses in order.
- Reset values:
  - state IDLE; `wait_cnt` = `burst_cnt` = 0; `resp_owner` = NONE;
  - `a_rvalid` = `b_rvalid` = 0; `rdata` outputs 0.
  - `mem_valid` follows the inputs combinationally, but is forced 0 while `rst` = 1. `x_ready` is likewise 0 while `rst` = 1.
- Reset during an outstanding read: the response is dropped and no `rvalid` occurs in the following cycle.
- Simultaneous A and B requests with `wait_cnt` < STARVE_LIMIT: A wins and `wait_cnt` increments.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, LOCKED);
  - owner encoding (NONE = 0, A = 1, B = 2);
  - counter width constant, 8.
- No sub-module. `wait_cnt` and `burst_cnt` are plain saturating registers inside the block.

## Test plan
- Only A reads addr 0x10 (memory word 0x1234_5678) → `a_ready` same cycle; next cycle `a_rvalid` = 1, `a_rdata` = 0x1234_5678; `b_rdata` = 0.
- A and B both valid for 20 cycles with STARVE_LIMIT = 8 → B granted at cycle 9 and then every 9th cycle; all other grants go to A.
- B locked burst of 4 reads with A continuously valid → 4 consecutive B grants, then A granted; `b_rvalid` on 4 consecutive cycles.
- B `b_lock` held with MAX_BURST = 16 and A valid → 16 B grants, A granted on cycle 17, then B re-arbitrates normally.
- Alternating A write (addr 0x20, wmask 4'b0011) and B read (addr 0x20) → B reads the updated low half in the following cycle; no `a_rvalid` is produced for the write.
- `rst` asserted in the cycle after an accepted A read → `a_rvalid` stays 0; state IDLE and counters 0 after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-requester memory arbiter
package mem_arb_pkg;

    localparam int CNT_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter2.sv
// rtl/mem_arbiter2.sv - priority arbiter sharing one memory port between A and B with
// starvation guard, bounded B lock bursts and one-cycle read response routing
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic                  a_write,
    input  logic [3:0]            a_wmask,
    input  logic [31:0]           a_wdata,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [31:0]           a_rdata,
    input  logic                  b_valid,
    input  logic                  b_write,
    input  logic                  b_lock,
    input  logic [3:0]            b_wmask,
    input  logic [31:0]           b_wdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [31:0]           b_rdata,
    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH:0]   BURST_MAX  = (CNT_WIDTH + 1)'(MAX_BURST);

    arb_state_t           state, state_nxt;
    owner_t               resp_owner, owner_nxt;
    logic [CNT_WIDTH-1:0] wait_cnt, wait_nxt;
    logic [CNT_WIDTH-1:0] burst_cnt, burst_nxt;
    logic [CNT_WIDTH:0]   burst_inc;
    logic                 grant_a, grant_b;

    assign burst_inc = {1'b0, burst_cnt} + (CNT_WIDTH + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_owner <= OWN_NONE;
            wait_cnt   <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            resp_owner <= owner_nxt;
            wait_cnt   <= wait_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        state_nxt = state;
        burst_nxt = burst_cnt;
        wait_nxt  = wait_cnt;
        owner_nxt = OWN_NONE;

        // A locked master that drops valid releases the port; nobody is granted that cycle
        if (!rst && !(state == LOCKED && !b_valid)) begin
            if (b_valid && (state == LOCKED || wait_cnt == STARVE_MAX || !a_valid))
                grant_b = 1'b1;
            else if (a_valid)
                grant_a = 1'b1;
        end

        if (state == IDLE) begin
            if (grant_b && b_lock && burst_inc < BURST_MAX) begin
                state_nxt = LOCKED;
                burst_nxt = burst_inc[CNT_WIDTH-1:0];
            end
        end else begin
            if (!b_valid || !b_lock || burst_inc >= BURST_MAX) begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end else if (grant_b) begin
                burst_nxt = burst_inc[CNT_WIDTH-1:0];
            end
        end

        if (!b_valid || grant_b)
            wait_nxt = '0;
        else if (wait_cnt < STARVE_MAX)
            wait_nxt = wait_cnt + CNT_WIDTH'(1);

        if (grant_a && !a_write)
            owner_nxt = OWN_A;
        else if (grant_b && !b_write)
            owner_nxt = OWN_B;
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_wmask = '0;
        mem_wdata = '0;
        mem_addr  = '0;
        if (grant_b) begin
            mem_valid = 1'b1;
            mem_write = b_write;
            mem_wmask = b_wmask;
            mem_wdata = b_wdata;
            mem_addr  = b_addr;
        end else if (grant_a) begin
            mem_valid = 1'b1;
            mem_write = a_write;
            mem_wmask = a_wmask;
            mem_wdata = a_wdata;
            mem_addr  = a_addr;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;

    // Gating with rst drops a response whose beat was accepted just before reset
    assign a_rvalid = !rst && resp_owner == OWN_A;
    assign b_rvalid = !rst && resp_owner == OWN_B;
    assign a_rdata  = a_rvalid ? mem_rdata : 32'h0;
    assign b_rdata  = b_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb/tb_mem_arbiter2.sv - randomized scoreboard bench for mem_arbiter2
module tb_mem_arbiter2;
    import mem_arb_pkg::*;

    localparam int AW = 14;
    localparam int SL = 8;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_write, a_ready, a_rvalid;
    logic [3:0]    a_wmask;
    logic [31:0]   a_wdata, a_rdata;
    logic [AW-1:0] a_addr;
    logic          b_valid, b_write, b_lock, b_ready, b_rvalid;
    logic [3:0]    b_wmask;
    logic [31:0]   b_wdata, b_rdata;
    logic [AW-1:0] b_addr;
    logic          mem_valid, mem_write;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter2 #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata),
        .a_addr(a_addr), .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_write(b_write), .b_lock(b_lock), .b_wmask(b_wmask),
        .b_wdata(b_wdata), .b_addr(b_addr), .b_ready(b_ready), .b_rvalid(b_rvalid),
        .b_rdata(b_rdata),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    // Memory environment: one-cycle read latency, garbage on idle cycles
    always @(posedge clk) begin
        if (mem_valid && mem_write)
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        if (mem_valid && !mem_write) mem_rdata <= mem[mem_addr];
        else                         mem_rdata <= $urandom;
    end

    typedef struct {
        int          cyc;
        logic        own_b;
        logic [31:0] data;
    } resp_t;
    resp_t q[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Reference model state: lock flag, wait and burst counts as plain integers
    bit m_locked = 1'b0;
    int m_wait   = 0;
    int m_burst  = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic step(input logic av, input logic aw, input logic [3:0] am,
                        input logic [31:0] ad, input logic [AW-1:0] aa,
                        input logic bv, input logic bw, input logic bl, input logic [3:0] bm,
                        input logic [31:0] bd, input logic [AW-1:0] ba, input logic r,
                        output logic ga, output logic gb);
        logic [39+AW:0] exp_cmd, act_cmd;
        @(posedge clk);
        #1;
        a_valid = av; a_write = aw; a_wmask = am; a_wdata = ad; a_addr = aa;
        b_valid = bv; b_write = bw; b_lock = bl; b_wmask = bm; b_wdata = bd; b_addr = ba;
        rst = r;
        #2;
        gb = !r && bv && (m_locked || m_wait == SL || !av);
        ga = !r && av && !gb && !(m_locked && !bv);
        if (gb)      exp_cmd = {1'b0, 1'b1, 1'b1, bw, bm, ba, bd};
        else if (ga) exp_cmd = {1'b1, 1'b0, 1'b1, aw, am, aa, ad};
        else         exp_cmd = '0;
        act_cmd = {a_ready, b_ready, mem_valid, mem_write, mem_wmask, mem_addr, mem_wdata};
        check("cmd", 128'(act_cmd), 128'(exp_cmd));

        if (r) begin
            while (q.size() > 0 && q[$].cyc == cyc) void'(q.pop_back());
            m_locked = 1'b0; m_wait = 0; m_burst = 0;
        end else begin
            if (gb) begin
                if (bw) ref_mem[ba] = merge(ref_mem[ba], bd, bm);
                else    q.push_back('{cyc + 1, 1'b1, ref_mem[ba]});
                if (!m_locked) begin
                    if (bl && 1 < MB) begin m_locked = 1'b1; m_burst = 1; end
                end else if (!bl || m_burst + 1 >= MB) begin
                    m_locked = 1'b0; m_burst = 0;
                end else begin
                    m_burst++;
                end
            end else if (m_locked) begin
                m_locked = 1'b0; m_burst = 0;
            end
            if (ga) begin
                if (aw) ref_mem[aa] = merge(ref_mem[aa], ad, am);
                else    q.push_back('{cyc + 1, 1'b0, ref_mem[aa]});
            end
            if (!bv || gb) m_wait = 0;
            else if (m_wait < SL) m_wait++;
        end
    endtask

    // Response monitor: every cycle, compare both response ports to the scoreboard head
    initial begin
        logic [65:0] exp_r;
        resp_t e;
        forever begin
            @(negedge clk);
            exp_r = '0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                exp_r = e.own_b ? {1'b0, 32'h0, 1'b1, e.data} : {1'b1, e.data, 1'b0, 32'h0};
            end
            check("resp", 128'({a_rvalid, a_rdata, b_rvalid, b_rdata}), 128'(exp_r));
        end
    end

    initial begin
        logic ga, gb;
        logic [31:0] d;
        int beats, first, last, run;
        bit started, done;

        for (int i = 0; i < (1 << AW); i++) begin
            d = (i < 64) ? $urandom : 32'h0;
            mem[i] = d; ref_mem[i] = d;
        end
        mem[16] = 32'h1234_5678; ref_mem[16] = 32'h1234_5678;

        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, ga, gb);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ga, gb);

        // Single A read of word 0x10
        step(1, 0, 4'hf, 0, 14'h10, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        check("a_read_ready", 128'(ga), 128'(1));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);

        // A and B contend for 20 cycles: B every 9th cycle
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 14'(i), 1, 0, 0, 0, 0, 14'(i + 1), 0, ga, gb);
            check("starve_grant", 128'(gb), 128'((i % 9) == 8));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);

        // Locked burst of 4 B reads against a continuously valid A
        beats = 0; first = 0; last = 0;
        for (int i = 0; i < 30 && beats < 4; i++) begin
            step(1, 0, 0, 0, 14'(i), 1, 0, beats < 3, 0, 0, 14'(i + 3), 0, ga, gb);
            if (gb) begin
                if (beats == 0) first = i;
                last = i;
                beats++;
            end
        end
        check("burst4_beats", 128'(beats), 128'(4));
        check("burst4_consecutive", 128'(last - first), 128'(3));
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 6, 0, ga, gb);
        check("burst4_then_a", 128'(ga), 128'(1));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);

        // Lock held: MAX_BURST grants then A
        run = 0; started = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step(1, 0, 0, 0, 14'(i), 1, 0, 1, 0, 0, 14'(i + 7), 0, ga, gb);
            if (gb) begin
                started = 1; run++;
            end else if (started) begin
                done = 1;
                check("burst16_then_a", 128'(ga), 128'(1));
            end
        end
        check("burst16_len", 128'(run), 128'(MB));
        check("burst16_released", 128'(done), 128'(1));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);

        // Alternating A partial write and B read of word 0x20
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 4'b0011, $urandom, 14'h20, 0, 0, 0, 0, 0, 0, 0, ga, gb);
            check("wr_grant_a", 128'(ga), 128'(1));
            step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 14'h20, 0, ga, gb);
            check("rd_grant_b", 128'(gb), 128'(1));
        end

        // Reset right after an accepted A read, with B waiting
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 14'(i), 1, 0, 0, 0, 0, 9, 0, ga, gb);
        step(1, 0, 0, 0, 14'h10, 1, 0, 0, 0, 0, 9, 0, ga, gb);
        step(1, 0, 0, 0, 14'h11, 1, 0, 0, 0, 0, 9, 1, ga, gb);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        check("rst_state", 128'(dut.state), 128'(IDLE));
        check("rst_wait", 128'(dut.wait_cnt), 128'(0));
        check("rst_burst", 128'(dut.burst_cnt), 128'(0));

        // Randomized phases with varying contention and lock probability
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                int pa, pb, pl;
                pa = (ph == 1) ? 95 : 60;
                pb = (ph >= 2) ? 95 : 50;
                pl = (ph == 3) ? 95 : 30;
                step($urandom_range(0, 99) < pa, $urandom_range(0, 2) == 0, 4'($urandom),
                     $urandom, 14'($urandom_range(0, 63)),
                     $urandom_range(0, 99) < pb, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 99) < pl, 4'($urandom), $urandom,
                     14'($urandom_range(0, 63)), $urandom_range(0, 99) == 0, ga, gb);
            end
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        @(negedge clk);
        #1;
        check("queue_empty", 128'(q.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
